// File: rtl/aq_axi_lite_master_pkg.sv
// Shared types and constants for the local-bus to AXI4-Lite master bridge.
package aq_axi_lite_master_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned RESP_W = 2;

  localparam logic [3:0] AXCACHE = 4'b0011;
  localparam logic [2:0] AXPROT  = 3'b000;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wbeat_t;

  // EXOKAY counts as success; only SLVERR/DECERR flag an error.
  function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/aq_axi_lite_master.sv
// Local-bus to AXI4-Lite master bridge; one outstanding single-beat transaction.
module aq_axi_lite_master
  import aq_axi_lite_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [3:0]            M_AXI_AWCACHE,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [STRB_W-1:0]     M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  input  logic [RESP_W-1:0]     M_AXI_BRESP,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [3:0]            M_AXI_ARCACHE,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [RESP_W-1:0]     M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  input  logic                  AQ_LOCAL_CS,
  input  logic                  AQ_LOCAL_RNW,
  input  logic [ADDR_WIDTH-1:0] AQ_LOCAL_ADDR,
  input  logic [STRB_W-1:0]     AQ_LOCAL_BE,
  input  logic [DATA_W-1:0]     AQ_LOCAL_WDATA,
  output logic                  AQ_LOCAL_ACK,
  output logic [DATA_W-1:0]     AQ_LOCAL_RDATA,
  output logic                  AQ_LOCAL_ERR
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  wbeat_t                wbeat_q, wbeat_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  // State and registered outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wbeat_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wbeat_q   <= wbeat_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wbeat_d   = wbeat_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (AQ_LOCAL_CS) begin
          addr_d  = AQ_LOCAL_ADDR;
          wbeat_d = '{data: AQ_LOCAL_WDATA, strb: AQ_LOCAL_BE};
          if (AQ_LOCAL_RNW) begin
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WADDR;
          end
        end
      end
      S_WADDR: begin
        // AW and W retire independently; leave once both are accepted.
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          ack_d    = 1'b1;
          err_d    = resp_is_err(M_AXI_BRESP);
          state_d  = S_DONE;
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          ack_d    = 1'b1;
          err_d    = resp_is_err(M_AXI_RRESP);
          rdata_d  = M_AXI_RDATA;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (!AQ_LOCAL_CS) state_d = S_IDLE;
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        bready_d  = 1'b0;
        rready_d  = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign M_AXI_AWADDR   = addr_q;
  assign M_AXI_AWCACHE  = AXCACHE;
  assign M_AXI_AWPROT   = AXPROT;
  assign M_AXI_AWVALID  = awvalid_q;
  assign M_AXI_WDATA    = wbeat_q.data;
  assign M_AXI_WSTRB    = wbeat_q.strb;
  assign M_AXI_WVALID   = wvalid_q;
  assign M_AXI_BREADY   = bready_q;
  assign M_AXI_ARADDR   = addr_q;
  assign M_AXI_ARCACHE  = AXCACHE;
  assign M_AXI_ARPROT   = AXPROT;
  assign M_AXI_ARVALID  = arvalid_q;
  assign M_AXI_RREADY   = rready_q;
  assign AQ_LOCAL_ACK   = ack_q;
  assign AQ_LOCAL_RDATA = rdata_q;
  assign AQ_LOCAL_ERR   = err_q;

endmodule

// File: tb/tb_aq_axi_lite_master.sv
// Scoreboard bench for aq_axi_lite_master with a delay-configurable AXI-Lite slave.
module tb_aq_axi_lite_master;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] M_AXI_AWADDR;
  logic [3:0]  M_AXI_AWCACHE;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [1:0]  M_AXI_BRESP;
  logic [31:0] M_AXI_ARADDR;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic        AQ_LOCAL_CS;
  logic        AQ_LOCAL_RNW;
  logic [31:0] AQ_LOCAL_ADDR;
  logic [3:0]  AQ_LOCAL_BE;
  logic [31:0] AQ_LOCAL_WDATA;
  logic        AQ_LOCAL_ACK;
  logic [31:0] AQ_LOCAL_RDATA;
  logic        AQ_LOCAL_ERR;

  aq_axi_lite_master #(.ADDR_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .AQ_LOCAL_CS(AQ_LOCAL_CS), .AQ_LOCAL_RNW(AQ_LOCAL_RNW), .AQ_LOCAL_ADDR(AQ_LOCAL_ADDR),
    .AQ_LOCAL_BE(AQ_LOCAL_BE), .AQ_LOCAL_WDATA(AQ_LOCAL_WDATA),
    .AQ_LOCAL_ACK(AQ_LOCAL_ACK), .AQ_LOCAL_RDATA(AQ_LOCAL_RDATA), .AQ_LOCAL_ERR(AQ_LOCAL_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Slave behaviour knobs
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic [1:0]  r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  logic [31:0] last_rdata = 32'h0;

  // Running totals of cycles each handshake signal was high
  int aw_hi = 0, w_hi = 0, ar_hi = 0, rr_hi = 0;

  // Values seen on the first cycle after CS was sampled
  logic        first_awv, first_wv, first_arv;
  logic [31:0] first_awaddr, first_wdata, first_araddr;
  logic [3:0]  first_wstrb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // AW / W / AR ready generators: ready after N cycles of valid
  initial begin : aw_slave
    int cnt;
    cnt = 0;
    M_AXI_AWREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      if (M_AXI_AWVALID) begin
        if (cnt >= aw_dly) M_AXI_AWREADY = 1'b1;
        else begin M_AXI_AWREADY = 1'b0; cnt++; end
      end else begin
        M_AXI_AWREADY = 1'b0; cnt = 0;
      end
    end
  end

  initial begin : w_slave
    int cnt;
    cnt = 0;
    M_AXI_WREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      if (M_AXI_WVALID) begin
        if (cnt >= w_dly) M_AXI_WREADY = 1'b1;
        else begin M_AXI_WREADY = 1'b0; cnt++; end
      end else begin
        M_AXI_WREADY = 1'b0; cnt = 0;
      end
    end
  end

  initial begin : ar_slave
    int cnt;
    cnt = 0;
    M_AXI_ARREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      if (M_AXI_ARVALID) begin
        if (cnt >= ar_dly) M_AXI_ARREADY = 1'b1;
        else begin M_AXI_ARREADY = 1'b0; cnt++; end
      end else begin
        M_AXI_ARREADY = 1'b0; cnt = 0;
      end
    end
  end

  // B / R responders: respond N cycles after the master starts waiting
  initial begin : b_slave
    int cnt;
    cnt = 0;
    M_AXI_BVALID = 1'b0;
    M_AXI_BRESP  = 2'b00;
    forever begin
      @(negedge ACLK);
      if (M_AXI_BREADY) begin
        if (cnt >= b_dly) begin M_AXI_BVALID = 1'b1; M_AXI_BRESP = b_resp_cfg; end
        else begin M_AXI_BVALID = 1'b0; cnt++; end
      end else begin
        M_AXI_BVALID = 1'b0; cnt = 0;
      end
    end
  end

  initial begin : r_slave
    int cnt;
    cnt = 0;
    M_AXI_RVALID = 1'b0;
    M_AXI_RDATA  = 32'h0;
    M_AXI_RRESP  = 2'b00;
    forever begin
      @(negedge ACLK);
      if (M_AXI_RREADY) begin
        if (cnt >= r_dly) begin
          M_AXI_RVALID = 1'b1; M_AXI_RDATA = r_data_cfg; M_AXI_RRESP = r_resp_cfg;
        end else begin
          M_AXI_RVALID = 1'b0; cnt++;
        end
      end else begin
        M_AXI_RVALID = 1'b0; cnt = 0;
      end
    end
  end

  // Handshake-signal activity and address/data stability tracking
  initial begin : activity
    logic        prev_awv, prev_wv, prev_arv;
    logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
    prev_awv = 1'b0; prev_wv = 1'b0; prev_arv = 1'b0;
    prev_awaddr = '0; prev_wdata = '0; prev_araddr = '0;
    forever begin
      @(negedge ACLK);
      if (M_AXI_AWVALID) aw_hi++;
      if (M_AXI_WVALID)  w_hi++;
      if (M_AXI_ARVALID) ar_hi++;
      if (M_AXI_RREADY)  rr_hi++;
      if (M_AXI_AWVALID && prev_awv) check("awaddr_stable", M_AXI_AWADDR, prev_awaddr);
      if (M_AXI_WVALID && prev_wv)   check("wdata_stable", M_AXI_WDATA, prev_wdata);
      if (M_AXI_ARVALID && prev_arv) check("araddr_stable", M_AXI_ARADDR, prev_araddr);
      prev_awv = M_AXI_AWVALID; prev_awaddr = M_AXI_AWADDR;
      prev_wv  = M_AXI_WVALID;  prev_wdata  = M_AXI_WDATA;
      prev_arv = M_AXI_ARVALID; prev_araddr = M_AXI_ARADDR;
    end
  end

  // Scoreboard monitor: every ACK must match the oldest queued expectation
  initial begin : monitor
    logic prev_ack;
    exp_t e;
    prev_ack = 1'b0;
    forever begin
      @(negedge ACLK);
      if (AQ_LOCAL_ACK) begin
        check("ack_one_cycle", prev_ack, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: actual ack=1 required no ack");
        end else begin
          e = exp_q.pop_front();
          check("err", AQ_LOCAL_ERR, e.err);
          check("rdata", AQ_LOCAL_RDATA, e.rdata);
        end
      end
      prev_ack = AQ_LOCAL_ACK;
    end
  end

  task automatic do_txn(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic exp_err, input int hold,
                        output int lat);
    exp_t e;
    if (rnw) last_rdata = r_data_cfg;
    e.err   = exp_err;
    e.rdata = last_rdata;
    exp_q.push_back(e);
    @(negedge ACLK);
    AQ_LOCAL_CS = 1'b1; AQ_LOCAL_RNW = rnw; AQ_LOCAL_ADDR = addr;
    AQ_LOCAL_BE = be;   AQ_LOCAL_WDATA = wd;
    lat = 0;
    do begin
      @(negedge ACLK);
      lat++;
      if (lat == 1) begin
        first_awv = M_AXI_AWVALID; first_wv = M_AXI_WVALID; first_arv = M_AXI_ARVALID;
        first_awaddr = M_AXI_AWADDR; first_wdata = M_AXI_WDATA;
        first_wstrb = M_AXI_WSTRB; first_araddr = M_AXI_ARADDR;
      end
    end while (!AQ_LOCAL_ACK && lat < 200);
    if (!AQ_LOCAL_ACK) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: actual no ack after %0d cycles required ack", lat);
    end
    repeat (hold) @(negedge ACLK);
    AQ_LOCAL_CS = 1'b0;
    @(negedge ACLK);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat, aw0, w0, ar0, rr0, waited;
    ARESETN = 1'b0;
    AQ_LOCAL_CS = 1'b0; AQ_LOCAL_RNW = 1'b0; AQ_LOCAL_ADDR = '0;
    AQ_LOCAL_BE = '0;   AQ_LOCAL_WDATA = '0;
    repeat (3) @(negedge ACLK);

    // Reset state
    check("rst_awvalid", M_AXI_AWVALID, 0);
    check("rst_wvalid", M_AXI_WVALID, 0);
    check("rst_arvalid", M_AXI_ARVALID, 0);
    check("rst_bready", M_AXI_BREADY, 0);
    check("rst_rready", M_AXI_RREADY, 0);
    check("rst_ack", AQ_LOCAL_ACK, 0);
    check("rst_err", AQ_LOCAL_ERR, 0);
    check("rst_rdata", AQ_LOCAL_RDATA, 0);
    check("rst_awaddr", M_AXI_AWADDR, 0);
    check("rst_araddr", M_AXI_ARADDR, 0);
    check("rst_wdata", M_AXI_WDATA, 0);
    check("rst_wstrb", M_AXI_WSTRB, 0);
    check("awcache", M_AXI_AWCACHE, 4'b0011);
    check("arcache", M_AXI_ARCACHE, 4'b0011);
    check("awprot", M_AXI_AWPROT, 3'b000);
    check("arprot", M_AXI_ARPROT, 3'b000);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // Zero-wait write
    aw0 = aw_hi; w0 = w_hi;
    do_txn(1'b0, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 1'b0, 0, lat);
    check("w0_awvalid_n1", first_awv, 1);
    check("w0_wvalid_n1", first_wv, 1);
    check("w0_awaddr", first_awaddr, 32'h0000_1000);
    check("w0_wdata", first_wdata, 32'hDEAD_BEEF);
    check("w0_wstrb", first_wstrb, 4'hF);
    check("w0_ack_latency", lat, 3);
    check("w0_aw_cycles", aw_hi - aw0, 1);
    check("w0_w_cycles", w_hi - w0, 1);

    // AWREADY delayed 3 cycles, WREADY immediate
    aw_dly = 3;
    aw0 = aw_hi; w0 = w_hi;
    do_txn(1'b0, 32'h0000_2004, 4'h3, 32'hCAFE_F00D, 1'b0, 0, lat);
    check("w1_aw_cycles", aw_hi - aw0, 4);
    check("w1_w_cycles", w_hi - w0, 1);
    check("w1_ack_latency", lat, 6);
    aw_dly = 0;

    // Read with RVALID delayed 5 cycles
    r_dly = 5; r_data_cfg = 32'h1234_5678; r_resp_cfg = 2'b00;
    rr0 = rr_hi; ar0 = ar_hi;
    do_txn(1'b1, 32'h0000_3008, 4'hF, 32'h0, 1'b0, 0, lat);
    check("r0_arvalid_n1", first_arv, 1);
    check("r0_araddr", first_araddr, 32'h0000_3008);
    check("r0_ar_cycles", ar_hi - ar0, 1);
    check("r0_rready_cycles", rr_hi - rr0, 6);
    check("r0_ack_latency", lat, 8);
    repeat (3) @(negedge ACLK);
    check("r0_rdata_held", AQ_LOCAL_RDATA, 32'h1234_5678);
    r_dly = 0;

    // Response codes: SLVERR, DECERR flag errors; EXOKAY does not
    r_data_cfg = 32'hA5A5_0001; r_resp_cfg = 2'b10;
    do_txn(1'b1, 32'h0000_3010, 4'hF, 32'h0, 1'b1, 0, lat);
    b_resp_cfg = 2'b11;
    do_txn(1'b0, 32'h0000_2010, 4'h1, 32'h0000_00AA, 1'b1, 0, lat);
    b_resp_cfg = 2'b01;
    do_txn(1'b0, 32'h0000_2014, 4'h8, 32'hBB00_0000, 1'b0, 0, lat);
    r_data_cfg = 32'h0F0F_F0F0; r_resp_cfg = 2'b01;
    do_txn(1'b1, 32'h0000_3014, 4'hF, 32'h0, 1'b0, 0, lat);
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00;
    check("rdata_after_write", AQ_LOCAL_RDATA, 32'h0F0F_F0F0);

    // CS held high 4 cycles after ACK: no second transaction
    aw0 = aw_hi; ar0 = ar_hi;
    do_txn(1'b0, 32'h0000_4000, 4'hF, 32'h5555_AAAA, 1'b0, 4, lat);
    check("hold_w_aw_cycles", aw_hi - aw0, 1);
    r_data_cfg = 32'h7777_0000;
    do_txn(1'b1, 32'h0000_4004, 4'hF, 32'h0, 1'b0, 4, lat);
    check("hold_r_ar_cycles", ar_hi - ar0, 1);

    // Reset while waiting for the write response
    b_dly = 20;
    @(negedge ACLK);
    AQ_LOCAL_CS = 1'b1; AQ_LOCAL_RNW = 1'b0; AQ_LOCAL_ADDR = 32'h0000_5000;
    AQ_LOCAL_BE = 4'hF; AQ_LOCAL_WDATA = 32'h1111_2222;
    waited = 0;
    do begin @(negedge ACLK); waited++; end while (!M_AXI_BREADY && waited < 50);
    check("rst_mid_bready_seen", M_AXI_BREADY, 1);
    ARESETN = 1'b0;
    #1;
    check("rst_mid_bready", M_AXI_BREADY, 0);
    check("rst_mid_awvalid", M_AXI_AWVALID, 0);
    check("rst_mid_wvalid", M_AXI_WVALID, 0);
    check("rst_mid_arvalid", M_AXI_ARVALID, 0);
    check("rst_mid_ack", AQ_LOCAL_ACK, 0);
    check("rst_mid_rdata", AQ_LOCAL_RDATA, 0);
    AQ_LOCAL_CS = 1'b0;
    last_rdata = 32'h0;
    b_dly = 0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    do_txn(1'b0, 32'h0000_6000, 4'hF, 32'h3333_4444, 1'b0, 0, lat);
    check("post_rst_w_latency", lat, 3);
    r_data_cfg = 32'h0BAD_CAFE;
    do_txn(1'b1, 32'h0000_6004, 4'hF, 32'h0, 1'b0, 0, lat);
    check("post_rst_r_latency", lat, 3);

    repeat (5) @(negedge ACLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aq_axi_lite_master.md
# aq_axi_lite_master

Local-bus to AXI4-Lite master bridge: turns single-beat local-bus requests (CS/RNW/ADDR/BE/WDATA) into AXI4-Lite write or read transactions and returns read data, completion ACK and response status. It sits between an internal controller and an AXI4-Lite interconnect, so a local-bus agent can reach AXI-Lite register slaves. One transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of AQ_LOCAL_ADDR and M_AXI_AWADDR/ARADDR.

Ports (one clock; reset is asynchronous and active-low; clock ACLK, reset ARESETN):
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  async active-low reset.
- M_AXI_AWADDR  out  ADDR_WIDTH  write address.
- M_AXI_AWCACHE  out  4  constant 4'b0011.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID / M_AXI_AWREADY  out / in  1  AW handshake.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  byte strobes.
- M_AXI_WVALID / M_AXI_WREADY  out / in  1  W handshake.
- M_AXI_BVALID / M_AXI_BREADY  in / out  1  B handshake.
- M_AXI_BRESP  in  2  write response.
- M_AXI_ARADDR  out  ADDR_WIDTH  read address.
- M_AXI_ARCACHE  out  4  constant 4'b0011.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID / M_AXI_ARREADY  out / in  1  AR handshake.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID / M_AXI_RREADY  in / out  1  R handshake.
- AQ_LOCAL_CS  in  1  request; held high until ACK seen.
- AQ_LOCAL_RNW  in  1  1 = read, 0 = write; sampled with CS.
- AQ_LOCAL_ADDR  in  ADDR_WIDTH  address; sampled with CS.
- AQ_LOCAL_BE  in  4  byte enables; sampled with CS.
- AQ_LOCAL_WDATA  in  32  write data; sampled with CS.
- AQ_LOCAL_ACK  out  1  one-cycle completion pulse.
- AQ_LOCAL_RDATA  out  32  read data; valid from ACK until next read completes.
- AQ_LOCAL_ERR  out  1  registered with ACK: 1 if BRESP/RRESP[1] set (SLVERR/DECERR).

## Operation
- States: S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE.
- S_IDLE: on CS=1, latch ADDR/BE/WDATA/RNW into registers; RNW=0 -> S_WADDR with AWVALID=WVALID=1; RNW=1 -> S_RADDR with ARVALID=1.
- S_WADDR: AWVALID drops in the cycle after its handshake, WVALID likewise, independently; either order or same cycle accepted. Both done -> S_WRESP.
- S_WRESP: BREADY=1; on BVALID capture BRESP -> S_DONE.
- S_RADDR: ARVALID held until ARREADY -> S_RDATA.
- S_RDATA: RREADY=1; on RVALID capture RDATA, RRESP -> S_DONE.
- S_DONE: ACK=1 on the first cycle only; stays until CS=0, then -> S_IDLE. CS still high after ACK never starts a second transaction.
- VALID signals never drop before handshake; AXI address/data/strobe outputs stable while VALID is high.
- BREADY/RREADY are 0 outside S_WRESP/S_RDATA; stray BVALID/RVALID ignored.
- ERR = resp[1]; EXOKAY (01) reported as success.
- Invalid state encoding -> S_IDLE.

## Timing
- Reset: all VALID/READY outputs 0, ACK 0, ERR 0, RDATA 0, AXI address/data/strobe 0, state S_IDLE.
- CS sampled at edge N -> AWVALID/WVALID/ARVALID high from cycle N+1.
- Zero-wait slave: write = AW/W handshake N+1, BVALID N+2, ACK N+3; read = AR N+1, RVALID N+2, ACK N+3.
- ACK exactly one cycle; minimum 1 cycle in S_IDLE between transactions (CS low required).
- Reset mid-transaction: all outputs to reset values immediately; no ACK for the aborted request.

## Structure
- Shared package: state encodings, AXCACHE (4'b0011) / AXPROT (3'b000) constants, RESP codes (OKAY, EXOKAY, SLVERR, DECERR).
- Single flat module; no sub-module.

## Test plan
- Write, zero-wait slave: CS, ADDR=0x0000_1000, BE=4'hF, WDATA=0xDEADBEEF -> AWADDR=0x1000, WDATA=0xDEADBEEF, WSTRB=0xF at N+1; ACK at N+3, ERR=0.
- Write, AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles stable, single ACK after B.
- Read with RVALID delayed 5 cycles, RDATA=0x12345678, RRESP=00 -> RREADY high throughout wait, ACK one cycle, AQ_LOCAL_RDATA=0x12345678 held after.
- Read returning RRESP=2'b10 -> ACK with ERR=1; write returning BRESP=2'b11 -> ACK with ERR=1.
- CS held high 4 cycles after ACK -> no second AWVALID/ARVALID until CS low then high again.
- ARESETN low while in S_WRESP -> BREADY, ACK, VALIDs 0 immediately; after release next request completes normally.
